instruction_encoder: RTL and testbench

// - Producer side of the 16-bit instruction word that the decode stage splits into

---
 rtl/ie_pkg.sv | 36 +++
 rtl/ie_fifo.sv | 59 +++++
 rtl/instruction_encoder.sv | 78 +++++++
 tb/tb_instruction_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ie_pkg.sv
// Shared instruction-word layout for the encoder and the decode stage.
package ie_pkg;

  localparam int OPCODE_W   = 4;
  localparam int PARAM_W    = 6;
  localparam int INSTR_W    = 16;
  localparam int MAX_OPCODE = 12;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int P1_MSB     = 11;
  localparam int P1_LSB     = 6;
  localparam int P2_MSB     = 5;
  localparam int P2_LSB     = 0;

  function automatic logic [INSTR_W-1:0] ie_pack(
    input logic [OPCODE_W-1:0] opcode,
    input logic [PARAM_W-1:0]  p1,
    input logic [PARAM_W-1:0]  p2
  );
    logic [INSTR_W-1:0] word;
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = opcode;
    word[P1_MSB:P1_LSB]         = p1;
    word[P2_MSB:P2_LSB]         = p2;
    return word;
  endfunction

  function automatic logic ie_is_legal(
    input logic [OPCODE_W-1:0] opcode,
    input int unsigned         max_opcode
  );
    return 32'(opcode) <= max_opcode;
  endfunction

endpackage

// File: rtl/ie_fifo.sv
// Synchronous FIFO buffering packed instruction words; head is read combinationally.
module ie_fifo
  import ie_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = INSTR_W,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               IE_clock,
  input  logic               IE_reset_n,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !clear && (level < LEVEL_W'(DEPTH));
  assign do_pop  = pop && !clear && (level != '0);

  // NOTE: storage is left unreset; rd_data is gated by level, so stale entries never leave the FIFO.
  always_ff @(posedge IE_clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge IE_clock or negedge IE_reset_n) begin
    if (!IE_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_encoder.sv
// Validates and packs opcode/parameter fields, buffers them, and streams
// addressed instruction words to the instruction-memory writer.
module instruction_encoder
  import ie_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 8,
  parameter int MAX_OPCODE = ie_pkg::MAX_OPCODE,
  parameter int LEVEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                IE_clock,
  input  logic                IE_reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [PARAM_W-1:0]  in_param1,
  input  logic [PARAM_W-1:0]  in_param2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instruction,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [LEVEL_W-1:0]  level,
  output logic                err_illegal,
  output logic [7:0]          illegal_count
);

  logic accept;
  logic legal;
  logic push;
  logic pop;

  // No full-bypass: a pop in the same cycle does not open a slot for the source.
  assign in_ready  = !flush && (level < LEVEL_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign legal     = ie_is_legal(in_opcode, MAX_OPCODE);
  assign push      = accept && legal;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !flush;

  ie_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (INSTR_W),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .IE_clock   (IE_clock),
    .IE_reset_n (IE_reset_n),
    .clear      (flush),
    .push       (push),
    .wr_data    (ie_pack(in_opcode, in_param1, in_param2)),
    .pop        (pop),
    .rd_data    (out_instruction),
    .level      (level)
  );

  always_ff @(posedge IE_clock or negedge IE_reset_n) begin
    if (!IE_reset_n) begin
      out_addr <= '0;
    end else if (flush) begin
      out_addr <= '0;
    end else if (pop) begin
      out_addr <= out_addr + ADDR_W'(1);
    end
  end

  // The rejection counter survives flush; only reset clears it.
  always_ff @(posedge IE_clock or negedge IE_reset_n) begin
    if (!IE_reset_n) begin
      err_illegal   <= 1'b0;
      illegal_count <= 8'h00;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && !legal && (illegal_count != 8'hFF))
        illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: handshake, FIFO ordering, illegal
// rejection, address wrap, flush and asynchronous reset.
module tb_instruction_encoder;

  logic        IE_clock = 1'b0;
  logic        IE_reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [5:0]  in_param1 = '0;
  logic [5:0]  in_param2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instruction;
  logic [7:0]  out_addr;
  logic [2:0]  level;
  logic        err_illegal;
  logic [7:0]  illegal_count;

  int checks = 0;
  int errors = 0;

  // Hand-packed vectors: {opcode, param1, param2}
  logic [3:0]  v_op [5] = '{4'd1, 4'd2, 4'd12, 4'd0, 4'd7};
  logic [5:0]  v_p1 [5] = '{6'h01, 6'h3F, 6'h00, 6'h15, 6'h2A};
  logic [5:0]  v_p2 [5] = '{6'h02, 6'h00, 6'h3F, 6'h2A, 6'h15};
  logic [15:0] v_w  [5] = '{16'h1042, 16'h2FC0, 16'hC03F, 16'h056A, 16'h7A95};

  always #5 IE_clock = ~IE_clock;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8), .MAX_OPCODE(12)) dut (
    .IE_clock        (IE_clock),
    .IE_reset_n      (IE_reset_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_param1       (in_param1),
    .in_param2       (in_param2),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_addr        (out_addr),
    .level           (level),
    .err_illegal     (err_illegal),
    .illegal_count   (illegal_count)
  );

  task automatic step();
    @(posedge IE_clock);
    #1;
  endtask

  task automatic drive(input int i);
    in_valid  = 1'b1;
    in_opcode = v_op[i];
    in_param1 = v_p1[i];
    in_param2 = v_p2[i];
  endtask

  task automatic do_reset();
    IE_reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_param1 = '0; in_param2 = '0;
    step();
    step();
    #2 IE_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    IE_reset_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", out_instruction); end
    checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", out_addr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_illegal); end
    checks++; if (illegal_count !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", illegal_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 4'd3; in_param1 = 6'h2A; in_param2 = 6'h15;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_instruction !== 16'h3A95) begin errors++; $display("FAIL single_instr got %h want 3a95", out_instruction); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL single_addr0 got %0d want 0", out_addr); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", out_valid); end
    checks++; if (out_addr !== 8'd1) begin errors++; $display("FAIL single_addr1 got %0d want 1", out_addr); end
    checks++; if (out_instruction !== 16'h0000) begin errors++; $display("FAIL single_instr_empty got %h want 0000", out_instruction); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, in_ready); end
      step();
    end
    drive(4);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
    step();
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL held_level got %0d want 4", level); end
    checks++; if (out_instruction !== v_w[0]) begin errors++; $display("FAIL stall_instr got %h want %h", out_instruction, v_w[0]); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL stall_addr got %0d want 0", out_addr); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_instruction !== v_w[i]) begin errors++; $display("FAIL drain_instr[%0d] got %h want %h", i, out_instruction, v_w[i]); end
      checks++; if (out_addr !== 8'(i)) begin errors++; $display("FAIL drain_addr[%0d] got %0d want %0d", i, out_addr, i); end
      step();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_done_valid got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 4'd13; in_param1 = 6'h01; in_param2 = 6'h02;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b want 1", err_illegal); end
    checks++; if (illegal_count !== 8'd1) begin errors++; $display("FAIL illegal_count1 got %0d want 1", illegal_count); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL illegal_nopush got %0d want 0", level); end
    step();
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end got %b want 0", err_illegal); end
    in_valid = 1'b1; in_opcode = 4'd15;
    repeat (300) step();
    in_valid = 1'b0;
    step();
    checks++; if (illegal_count !== 8'hFF) begin errors++; $display("FAIL illegal_sat got %h want ff", illegal_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_sat_empty got %b want 0", out_valid); end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      drive(k % 5);
      step();
      in_valid = 1'b0;
      step();
    end
    checks++; if (out_addr !== 8'd255) begin errors++; $display("FAIL preload_addr got %0d want 255", out_addr); end
    out_ready = 1'b0;
    drive(0); step();
    drive(1); step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_instruction !== v_w[0]) begin errors++; $display("FAIL wrap_instr0 got %h want %h", out_instruction, v_w[0]); end
    checks++; if (out_addr !== 8'd255) begin errors++; $display("FAIL wrap_addr255 got %0d want 255", out_addr); end
    out_ready = 1'b1;
    step();
    checks++; if (out_instruction !== v_w[1]) begin errors++; $display("FAIL wrap_instr1 got %h want %h", out_instruction, v_w[1]); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL wrap_addr0 got %0d want 0", out_addr); end
    step();
    checks++; if (out_addr !== 8'd1) begin errors++; $display("FAIL wrap_addr1 got %0d want 1", out_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_opcode = 4'd14;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(i); step(); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL preflush_level got %0d want 3", level); end
    checks++; if (out_addr !== 8'd1) begin errors++; $display("FAIL preflush_addr got %0d want 1", out_addr); end
    flush = 1'b1; drive(2); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL flush_addr got %0d want 0", out_addr); end
    checks++; if (out_instruction !== 16'h0000) begin errors++; $display("FAIL flush_instr got %h want 0000", out_instruction); end
    checks++; if (illegal_count !== 8'd1) begin errors++; $display("FAIL flush_count got %0d want 1", illegal_count); end
    drive(3);
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_instruction !== v_w[3]) begin errors++; $display("FAIL postflush_instr got %h want %h", out_instruction, v_w[3]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    drive(0); step();
    drive(1); step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(k + 2);
      #1;
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level[%0d] got %0d want 2", k, level); end
      checks++; if (out_instruction !== v_w[k]) begin errors++; $display("FAIL b2b_instr[%0d] got %h want %h", k, out_instruction, v_w[k]); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_end_level got %0d want 2", level); end
    checks++; if (out_instruction !== v_w[3]) begin errors++; $display("FAIL b2b_end_instr got %h want %h", out_instruction, v_w[3]); end
    checks++; if (out_addr !== 8'd3) begin errors++; $display("FAIL b2b_addr got %0d want 3", out_addr); end
    #2 IE_reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (out_instruction !== 16'h0000) begin errors++; $display("FAIL midrst_instr got %h want 0000", out_instruction); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL midrst_addr got %0d want 0", out_addr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_illegal();
    test_addr_wrap();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
